// File: rtl/apb_timer_if.sv
// rtl/apb_timer_if.sv - APB bus bundle for the timer responder
interface apb_timer_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB responder with a 32-bit down-counting timer and interrupt
module apb_timer #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        pclk,
    input  logic        prstn,
    apb_timer_if.slave  bus,
    output logic        irq
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        exp_q, exp_d;
    logic        irq_q, irq_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] prdata_q, prdata_d;

    logic        acc_err;
    logic        commit;
    logic        expire;
    logic        go_resp;
    logic [31:0] rd_val;

    // Register file, timer tick and write commit; writes override the tick
    always_comb begin
        acc_err = (bus.paddr[1:0] != 2'd0) || (bus.paddr[31:4] != 28'd0) ||
                  (bus.pwrite && (bus.paddr[3:2] == 2'd2));
        commit  = (state_q == S_RESP) && bus.psel && bus.pwrite && !acc_err;
        expire  = ctrl_q[0] && (count_q == 32'd0);

        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;

        if (ctrl_q[0]) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (ctrl_q[1]) begin
                count_d = load_q;
            end else begin
                ctrl_d[0] = 1'b0;
            end
        end

        if (commit) begin
            case (bus.paddr[3:2])
                2'd0: ctrl_d = bus.pwdata[2:0];
                2'd1: begin
                    load_d  = bus.pwdata;
                    count_d = bus.pwdata;
                end
                2'd3: if (bus.pwdata[0]) exp_d = 1'b0;
                default: ;
            endcase
        end

        // A fresh expiry beats a simultaneous clear
        if (expire) exp_d = 1'b1;

        irq_d = exp_q & ctrl_q[2];
    end

    // Read mux sees the values that will be present during the response cycle
    always_comb begin
        rd_val = 32'd0;
        case (bus.paddr[3:2])
            2'd0: rd_val = {29'd0, ctrl_d};
            2'd1: rd_val = load_d;
            2'd2: rd_val = count_d;
            2'd3: rd_val = {31'd0, exp_d};
            default: ;
        endcase
    end

    // Bus handshake: setup -> wait states -> one-cycle response
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        go_resp   = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    wcnt_d = 3'd0;
                    if (WS == 4'd0) go_resp = 1'b1;
                    else            state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.psel) begin
                    state_d = S_IDLE;
                end else if (bus.penable) begin
                    wcnt_d = wcnt_q + 3'd1;
                    if (({1'b0, wcnt_q} + 4'd1) == WS) go_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (go_resp) begin
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = acc_err;
            prdata_d  = acc_err ? 32'd0 : rd_val;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge pclk) begin
        if (!prstn) begin
            state_q   <= S_IDLE;
            wcnt_q    <= 3'd0;
            ctrl_q    <= 3'd0;
            load_q    <= 32'd0;
            count_q   <= 32'd0;
            exp_q     <= 1'b0;
            irq_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            exp_q     <= exp_d;
            irq_q     <= irq_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;
    assign irq         = irq_q;
endmodule

// File: tb/tb_apb_timer.sv
// tb/tb_apb_timer.sv - self-checking bench for apb_timer
module tb_apb_timer;
    localparam int WS = 1;

    logic pclk = 1'b0;
    logic prstn = 1'b0;
    logic irq;
    apb_timer_if bus();

    apb_timer #(.WAIT_STATES(WS)) dut (
        .pclk  (pclk),
        .prstn (prstn),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_bad = 0;

    logic [2:0]  m_ctrl;
    logic [31:0] m_load, m_count;
    bit          m_exp, m_irq;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        bit          err;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit m_err(input bit wr, input logic [31:0] a);
        return (a[1:0] != 2'd0) || (a[31:4] != 28'd0) || (wr && a[3:0] == 4'h8);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[3:0])
            4'h0:    return {29'd0, m_ctrl};
            4'h4:    return m_load;
            4'h8:    return m_count;
            4'hC:    return {31'd0, m_exp};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_ctrl = 3'd0; m_load = 0; m_count = 0; m_exp = 0; m_irq = 0;
    endtask

    // One clock: advance the reference, then check outputs in the new cycle
    task automatic cyc(input bit commit, input logic [31:0] a, input logic [31:0] d, input bit rdy_next);
        logic [2:0]  c;
        logic [31:0] ld, cn;
        bit          e, fired;
        c = m_ctrl; ld = m_load; cn = m_count; e = m_exp; fired = 0;
        if (m_ctrl[0]) begin
            if (m_count != 0) cn = m_count - 1;
            else begin
                fired = 1; e = 1;
                if (m_ctrl[1]) cn = m_load;
                else           c[0] = 1'b0;
            end
        end
        if (commit) begin
            if (a[3:0] == 4'h0) c = d[2:0];
            else if (a[3:0] == 4'h4) begin ld = d; cn = d; end
            else if (a[3:0] == 4'hC && d[0] && !fired) e = 0;
        end
        @(posedge pclk); #1;
        m_irq = m_exp & m_ctrl[2];
        m_ctrl = c; m_load = ld; m_count = cn; m_exp = e;
        chk("irq", 32'(irq), 32'(m_irq));
        if (!rdy_next) begin
            chk("pready_idle", 32'(bus.pready), 32'd0);
            chk("pslverr_idle", 32'(bus.pslverr), 32'd0);
            chk("prdata_idle", bus.prdata, 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output bit err);
        bit e_exp;
        e_exp = m_err(wr, a);
        bus.psel = 1; bus.penable = 0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
        cyc(0, 0, 0, WS == 0);
        bus.penable = 1;
        for (int k = 1; k <= WS; k++) cyc(0, 0, 0, k == WS);
        chk("pready_resp", 32'(bus.pready), 32'd1);
        chk("pslverr_resp", 32'(bus.pslverr), 32'(e_exp));
        if (!wr || e_exp) chk("prdata_resp", bus.prdata, e_exp ? 32'd0 : m_read(a));
        rdata = bus.prdata;
        err = bus.pslverr;
        cyc(wr && !e_exp, a, d, 0);
        bus.psel = 0; bus.penable = 0;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r; bit e;
        xfer(1, a, d, r, e);
    endtask

    task automatic rd_const(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r; bit e;
        xfer(0, a, 0, r, e);
        chk(nm, r, exp);
    endtask

    task automatic do_reset();
        prstn = 0; bus.psel = 0; bus.penable = 0;
        @(posedge pclk); #1;
        m_reset();
        chk("rst_pready", 32'(bus.pready), 32'd0);
        chk("rst_pslverr", 32'(bus.pslverr), 32'd0);
        chk("rst_prdata", bus.prdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        prstn = 1;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] addrs[10];
        bit e;
        int guard;

        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
        m_reset();
        repeat (2) @(posedge pclk);
        do_reset();

        tbl[0] = '{0, 32'h0,  32'h0, 32'h0, 0};
        tbl[1] = '{0, 32'h4,  32'h0, 32'h0, 0};
        tbl[2] = '{0, 32'h8,  32'h0, 32'h0, 0};
        tbl[3] = '{0, 32'hC,  32'h0, 32'h0, 0};
        tbl[4] = '{1, 32'h8,  32'h5, 32'h0, 1};
        tbl[5] = '{0, 32'h10, 32'h0, 32'h0, 1};
        tbl[6] = '{1, 32'h2,  32'h7, 32'h0, 1};
        tbl[7] = '{0, 32'h5,  32'h0, 32'h0, 1};
        tbl[8] = '{0, 32'h4,  32'h0, 32'h0, 0};
        tbl[9] = '{0, 32'h8,  32'h0, 32'h0, 0};
        for (int i = 0; i < 10; i++) begin
            xfer(tbl[i].wr, tbl[i].addr, tbl[i].data, r, e);
            chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].err));
            if (!tbl[i].wr || tbl[i].err) chk($sformatf("tbl%0d_rdata", i), r, tbl[i].rdata);
        end

        // One-shot countdown
        wr_reg(32'h4, 32'd5);
        wr_reg(32'h0, 32'h1);
        rd_const("oneshot_first_count", 32'h8, 32'd3);
        for (int i = 0; i < 3; i++) rd_const("oneshot_count", 32'h8, m_count > 1 ? m_count - 2 : 0);
        idle(6);
        rd_const("oneshot_exp", 32'hC, 32'd1);
        rd_const("oneshot_en_clear", 32'h0, 32'd0);
        wr_reg(32'hC, 32'h1);
        rd_const("status_cleared", 32'hC, 32'd0);

        // Auto-reload with interrupt; clear on the expiry edge
        wr_reg(32'h4, 32'd3);
        wr_reg(32'h0, 32'h7);
        idle(12);
        guard = 0;
        while (!(m_count == 2 && m_ctrl[0]) && guard < 10) begin
            idle(1);
            guard++;
        end
        chk("align_timeout", 32'(guard < 10), 32'd1);
        wr_reg(32'hC, 32'h1);
        rd_const("set_beats_clear", 32'hC, 32'd1);
        chk("irq_high", 32'(irq), 32'd1);

        // LOAD write while counting
        wr_reg(32'h0, 32'h0);
        wr_reg(32'hC, 32'h1);
        wr_reg(32'h4, 32'd1000);
        wr_reg(32'h0, 32'h1);
        wr_reg(32'h4, 32'd100);
        rd_const("load_while_tick", 32'h8, 32'd98);
        wr_reg(32'h0, 32'h0);

        // Abort by dropping psel during the wait state
        bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 32'h4; bus.pwdata = 32'hAA;
        cyc(0, 0, 0, 0);
        bus.psel = 0; bus.penable = 0;
        idle(3);
        rd_const("abort_load", 32'h4, 32'd100);

        // Reset in the middle of a transfer
        bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 32'h4; bus.pwdata = 32'h55;
        cyc(0, 0, 0, 0);
        bus.penable = 1;
        do_reset();
        idle(2);
        rd_const("rst_load", 32'h4, 32'd0);
        rd_const("rst_ctrl", 32'h0, 32'd0);

        // Randomized traffic against the reference
        addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4, 32'hC, 32'h10, 32'h2, 32'h8000_0004};
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = addrs[$urandom_range(0, 9)];
            xfer($urandom_range(0, 1) == 1, a, 32'($urandom_range(0, 15)), r, e);
            idle($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_timer.md
# apb_timer

APB responder that exposes a 32-bit down-counting timer through four memory-mapped registers, with programmable wait states and error responses. It sits on the same APB bus as the RAM responder and is driven by the bus initiator (bench or bridge). An interrupt output is provided for the system. All transfers follow the APB setup/access protocol with `pready`/`pslverr` handshaking.

## Interface
- `WAIT_STATES`, default 1: number of access-phase cycles with `pready` low before completion, range 0..7.
- `pclk` input 1: sole clock; all logic on the rising edge.
- `prstn` input 1: reset, synchronous and active-low.
- `psel` input 1: slave select.
- `penable` input 1: access-phase strobe.
- `pwrite` input 1: 1 = write, 0 = read.
- `paddr` input 32: byte address; only `paddr[3:0]` decoded, `paddr[31:4]` must be 0.
- `pwdata` input 32: write data.
- `prdata` output 32: read data, valid only while `pready` = 1.
- `pready` output 1: transfer completion.
- `pslverr` output 1: error response, valid only while `pready` = 1.
- `irq` output 1: timer interrupt, level.

## Operation
- Register map (byte offsets):
  - 0x0 CTRL, RW. bit0 EN, bit1 RELOAD, bit2 IRQEN; bits 31:3 read 0.
  - 0x4 LOAD, RW, 32 bits.
  - 0x8 COUNT, RO.
  - 0xC STATUS. bit0 EXP; writing 1 clears it, writing 0 has no effect.
- Error (`pslverr` = 1, no state change, `prdata` = 0) on any of:
  - `paddr[1:0]` ≠ 0.
  - `paddr[31:4]` ≠ 0.
  - A write to COUNT.
- Writing LOAD also sets COUNT to `pwdata` on the same edge.
- Timer behaviour while EN = 1, once per cycle:
  - COUNT > 0: COUNT decrements by 1.
  - COUNT = 0: set EXP. If RELOAD = 1, COUNT ← LOAD. Otherwise COUNT stays 0 and EN clears.
- EN = 0: COUNT holds.
- `irq` = EXP & IRQEN, registered version.
- Bus FSM:
  - IDLE → WAIT on `psel` & !`penable`; the wait counter loads 0.
  - WAIT: the counter increments each cycle while `psel` & `penable`. When it reaches `WAIT_STATES`, go to RESP.
  - RESP: `pready` = 1 for exactly one cycle, then return to IDLE.
  - If `psel` drops in WAIT or RESP: the transfer aborts, the FSM returns to IDLE, there is no write side-effect, and `pready` stays 0.
- Simultaneous events:
  - LOAD write and timer tick on the same edge: the write wins (COUNT = `pwdata`).
  - STATUS clear and new expiry on the same edge: set wins (EXP = 1).
  - CTRL write with EN = 1 on the expiry edge: the written value wins.
- Reads of COUNT return the value present in the RESP cycle.

## Timing
- Setup cycle S has `psel` = 1 and `penable` = 0.
- `pready`, `prdata` and `pslverr` are registered. They are high/valid in cycle S+1+`WAIT_STATES` and low in all other cycles.
- Write data commits at the rising edge that ends the `pready` cycle. Reads reflect register state at the start of that cycle.
- A back-to-back setup cycle may immediately follow the `pready` cycle.
- `irq` rises one cycle after EXP sets, and falls one cycle after EXP or IRQEN clears.
- Reset (`prstn` = 0 at a rising edge):
  - CTRL, LOAD, COUNT and EXP clear to 0.
  - `pready` = 0, `pslverr` = 0, `prdata` = 0, `irq` = 0.
  - The FSM goes to IDLE.
  - Reset mid-transfer abandons the transfer with no side-effect.

## Test plan
- Reset, then read all four registers with `WAIT_STATES` = 1 → each read is 0x0, `pready` appears 2 cycles after setup, `pslverr` = 0.
- Write LOAD = 5, then CTRL = 0x1 → COUNT reads decreasing values, EXP = 1 after reaching 0, and EN reads 0 afterwards. A STATUS write of 0x1 clears EXP.
- LOAD = 3, CTRL = 0x7 → COUNT cycles 3,2,1,0,3,…. `irq` = 1 one cycle after the first expiry. Clearing STATUS while it expires again leaves EXP = 1.
- Write to 0x8, read 0x10, write 0x2 → `pslverr` = 1 with `pready`, `prdata` = 0, and all registers unchanged.
- Write LOAD = 100 on the same edge COUNT would decrement → COUNT reads 100 minus elapsed cycles, with no lost or extra decrement.
- Drop `psel` during WAIT of a LOAD write with value 0xAA, and separately assert `prstn` = 0 mid-transfer → LOAD unchanged, `pready` never asserted, and all outputs 0 after reset.
